tx_burst_src: RTL and testbench

- Parametrised valid/ready burst transmitter; successor to the single-word TX/VALID handshake source.
- On a start pulse it emits a burst of len_i words, either an incrementing pattern from base_i or a constant base_i.
- Emits one word per cycle while the sink is ready, flags the final beat, and signals completion with a one-cycle pulse.
- Sits between a control/test sequencer and any valid/ready sink in the datapath.

---
 rtl/tx_pkg.sv | 16 +
 rtl/tx_pattern_gen.sv | 36 +++
 rtl/tx_burst_src.sv | 126 ++++++++++++
 tb/tb_tx_burst_src.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the burst transmitter.
//   tx_state_e : burst FSM states (IDLE/SEND/DONE, 2-bit encoding 00/01/10)
//   MODE_INC   : data word increments per transferred beat
//   MODE_CONST : data word stays at the base value for the whole burst
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } tx_state_e;

  localparam logic MODE_INC   = 1'b0;
  localparam logic MODE_CONST = 1'b1;

endpackage

// File: rtl/tx_pattern_gen.sv
// Data word register for the burst transmitter: load, increment or hold.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset, clears the word to 0
//   load_i  : load base_i (takes priority over step_i)
//   step_i  : increment the word by one, wrapping modulo 2^DATA_W
//   base_i  : value loaded on load_i
//   data_o  : registered data word
module tx_pattern_gen
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] base_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (load_i) begin
      r_data <= base_i;
    end else if (step_i) begin
      r_data <= r_data + DATA_W'(1);
    end
  end

  assign data_o = r_data;

endmodule

// File: rtl/tx_burst_src.sv
// Valid/ready burst transmitter. A start request in IDLE latches length,
// base word and mode, then emits len beats (incrementing or constant),
// flags the final beat with last_o and pulses done_o once afterwards.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start_i  : burst request, sampled only in IDLE
//   len_i    : burst length in beats (0 ignores the request)
//   base_i   : first data word
//   mode_i   : 0 = increment per beat, 1 = constant word
//   ready_i  : sink ready
//   valid_o  : data_o valid
//   data_o   : transmitted word
//   last_o   : final beat marker, qualified by valid_o
//   busy_o   : high in SEND and DONE
//   done_o   : one-cycle pulse after the final beat is accepted
// All outputs are registered.
module tx_burst_src
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] base_i,
  input  logic              mode_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  tx_state_e        r_state;
  tx_state_e        w_state_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_last;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic w_accept;
  logic w_xfer;
  logic w_final;
  logic w_step;

  assign w_accept = (r_state == IDLE) && start_i && (len_i != '0);
  assign w_xfer   = r_valid && ready_i;
  assign w_final  = w_xfer && r_last;
  // The final beat does not advance the word, so data_o holds it through DONE.
  assign w_step   = w_xfer && !w_final && (r_mode == MODE_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = SEND;
      SEND:    if (w_final)  w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Status flags are derived from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= (w_state_next == SEND);
      r_busy  <= (w_state_next != IDLE);
      r_done  <= (w_state_next == DONE);
    end
  end

  // Burst context, beat counter and last-beat flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_mode <= MODE_INC;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_len  <= len_i;
      r_mode <= mode_i;
      r_cnt  <= '0;
      r_last <= (len_i == LEN_W'(1));
    end else if (w_final) begin
      r_last <= 1'b0;
    end else if (w_xfer) begin
      r_cnt  <= r_cnt + LEN_W'(1);
      // Next beat is final when its index equals len-1.
      r_last <= ((r_cnt + LEN_W'(1)) == (r_len - LEN_W'(1)));
    end
  end

  tx_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (w_accept),
    .step_i (w_step),
    .base_i (base_i),
    .data_o (data_o)
  );

  assign valid_o = r_valid;
  assign last_o  = r_last;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

// File: tb/tb_tx_burst_src.sv
// Self-checking bench for tx_burst_src: a per-cycle vector table plus
// hand-written sequences for the long constant burst and mid-burst reset.
module tb_tx_burst_src;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 4;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic [DATA_W-1:0] base_i;
  logic              mode_i;
  logic              ready_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              last_o;
  logic              busy_o;
  logic              done_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic [7:0] base;
    logic       mode;
    logic       ready;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       eb;
    logic       edn;
  } vec_t;

  vec_t vecs[$];

  tx_burst_src #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .len_i   (len_i),
    .base_i  (base_i),
    .mode_i  (mode_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [7:0] ed,
                       input logic el, input logic eb, input logic edn);
    n_checks++;
    if ({valid_o, data_o, last_o, busy_o, done_o} === {ev, ed, el, eb, edn}) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got v=%b d=%h l=%b b=%b dn=%b, expected v=%b d=%h l=%b b=%b dn=%b",
               name, valid_o, data_o, last_o, busy_o, done_o, ev, ed, el, eb, edn);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic vec_t mk(logic r, logic s, logic [3:0] l, logic [7:0] b, logic m,
                              logic rd, logic ev, logic [7:0] ed, logic el, logic eb,
                              logic edn);
    vec_t v;
    v.rst = r; v.start = s; v.len = l; v.base = b; v.mode = m; v.ready = rd;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.edn = edn;
    return v;
  endfunction

  initial begin
    int beats;
    rst = 1'b1; start_i = 1'b0; len_i = '0; base_i = '0; mode_i = 1'b0; ready_i = 1'b1;

    //             rst st len base  md rdy   v  data  l  b  dn
    // Reset, then start with len 0 ignored
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h77, 0, 1,  0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h77, 0, 1,  0, 8'h00, 0, 0, 0));
    // Incrementing burst 0x10, len 4
    vecs.push_back(mk(0, 1, 4, 8'h10, 0, 1,  1, 8'h10, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4, 8'h10, 0, 1,  1, 8'h11, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4, 8'h10, 0, 1,  1, 8'h12, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4, 8'h10, 0, 1,  1, 8'h13, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4, 8'h10, 0, 1,  0, 8'h13, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4, 8'h10, 0, 1,  0, 8'h13, 0, 0, 0));
    // Backpressure: len 3, ready low 3 cycles on beat 2
    vecs.push_back(mk(0, 1, 3, 8'h20, 0, 1,  1, 8'h20, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'h20, 0, 1,  1, 8'h21, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'h20, 0, 0,  1, 8'h21, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'h20, 0, 0,  1, 8'h21, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'h20, 0, 0,  1, 8'h21, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'h20, 0, 1,  1, 8'h22, 1, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'h20, 0, 1,  0, 8'h22, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3, 8'h20, 0, 1,  0, 8'h22, 0, 0, 0));
    // Incrementing wrap 0xFE, len 3
    vecs.push_back(mk(0, 1, 3, 8'hFE, 0, 1,  1, 8'hFE, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'hFE, 0, 1,  1, 8'hFF, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'hFE, 0, 1,  1, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'hFE, 0, 1,  0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3, 8'hFE, 0, 1,  0, 8'h00, 0, 0, 0));
    // Single beat
    vecs.push_back(mk(0, 1, 1, 8'h5A, 0, 1,  1, 8'h5A, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h5A, 0, 1,  0, 8'h5A, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 8'h5A, 0, 1,  0, 8'h5A, 0, 0, 0));
    // Constant 2-beat burst with start pulsed in SEND and DONE
    vecs.push_back(mk(0, 1, 2, 8'h30, 1, 1,  1, 8'h30, 0, 1, 0));
    vecs.push_back(mk(0, 1, 5, 8'h99, 0, 0,  1, 8'h30, 0, 1, 0));
    vecs.push_back(mk(0, 1, 5, 8'h99, 0, 1,  1, 8'h30, 1, 1, 0));
    vecs.push_back(mk(0, 1, 5, 8'h99, 0, 1,  0, 8'h30, 0, 1, 1));
    vecs.push_back(mk(0, 1, 5, 8'h99, 0, 1,  0, 8'h30, 0, 0, 0));
    vecs.push_back(mk(0, 0, 5, 8'h99, 0, 1,  0, 8'h30, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; start_i = vecs[i].start; len_i = vecs[i].len;
      base_i = vecs[i].base; mode_i = vecs[i].mode; ready_i = vecs[i].ready;
      step();
      check($sformatf("vec[%0d]", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eb,
            vecs[i].edn);
    end

    // Constant 15-beat burst; inputs changed after latching must not matter.
    start_i = 1'b1; len_i = 4'd15; base_i = 8'hA5; mode_i = 1'b1; ready_i = 1'b1;
    step();
    start_i = 1'b0; len_i = 4'd2; base_i = 8'h00; mode_i = 1'b0;
    beats = 0;
    while (valid_o && beats < 20) begin
      check($sformatf("const_beat%0d", beats), 1'b1, 8'hA5, (beats == 14), 1'b1, 1'b0);
      beats++;
      step();
    end
    check_int("const_count", beats, 15);
    check("const_done", 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
    step();
    check("const_idle", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);

    // Reset after beat 3 of an 8-beat burst.
    start_i = 1'b1; len_i = 4'd8; base_i = 8'h40; mode_i = 1'b0; ready_i = 1'b1;
    step();
    start_i = 1'b0;
    check("rst_mid_b0", 1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
    step(); step(); step();
    check("rst_mid_b3", 1'b1, 8'h43, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    check("rst_mid_abort", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check("rst_mid_nodone", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1; len_i = 4'd2; base_i = 8'h50;
    step();
    start_i = 1'b0;
    check("post_rst_b0", 1'b1, 8'h50, 1'b0, 1'b1, 1'b0);
    step();
    check("post_rst_b1", 1'b1, 8'h51, 1'b1, 1'b1, 1'b0);
    step();
    check("post_rst_done", 1'b0, 8'h51, 1'b0, 1'b1, 1'b1);
    step();
    check("post_rst_idle", 1'b0, 8'h51, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
